// File: rtl/cpu_run_ctrl.sv
// Sequencing controller for the single-cycle RISC-V core: streams a program into IMEM,
// rewinds the PC, then free-runs or single-steps the core with self-loop halt detection.
//
// state    | meaning
// ---------+----------------------------------------------------------
// IDLE     | waiting for a host command
// LD_RST   | core reset pulse, PC forced to 0 before the load
// LD_WAIT  | ready for the next load word from the host
// LD_WRITE | IMEM write strobe at the current PC
// LD_ADV   | PC+4 pulse to move to the next IMEM slot
// LD_END   | core reset pulse, PC back to 0 after the load
// RUN      | core free-running, watching for an unchanged PC
// STEP     | core executes exactly one instruction
// HALTED   | self-loop detected, core stopped
module cpu_run_ctrl #(
    parameter int MAX_WORDS   = 256,
    parameter int CYC_W       = 32,
    parameter int HALT_REPEAT = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       cmd_load,
    input  logic                       cmd_run,
    input  logic                       cmd_step,
    input  logic                       cmd_halt,
    input  logic                       host_valid,
    input  logic [31:0]                host_data,
    input  logic                       host_last,
    output logic                       host_ready,
    input  logic [31:0]                cpu_pc,
    output logic                       cpu_reset,
    output logic                       cpu_start,
    output logic                       cpu_up,
    output logic                       cpu_down,
    output logic [31:0]                imem_write_instr,
    output logic                       imem_write_en,
    output logic                       busy,
    output logic                       halted,
    output logic                       error,
    output logic [$clog2(MAX_WORDS):0] word_count,
    output logic [CYC_W-1:0]           cycle_count
);

    localparam int WC_W = $clog2(MAX_WORDS) + 1;
    localparam int SC_W = $clog2(HALT_REPEAT + 1);
    localparam logic [WC_W-1:0] WC_MAX = WC_W'(MAX_WORDS);
    localparam logic [SC_W-1:0] SC_HALT = SC_W'(HALT_REPEAT);

    typedef enum logic [3:0] {
        IDLE, LD_RST, LD_WAIT, LD_WRITE, LD_ADV, LD_END, RUN, STEP, HALTED
    } state_t;

    state_t            state;
    state_t            state_next;
    logic              last_q;
    logic              first_run;
    logic [31:0]       pc_prev;
    logic [SC_W-1:0]   same_cnt;
    logic [SC_W-1:0]   same_next;
    logic              load_go;
    logic              accept;

    assign cpu_down = 1'b0;
    assign accept   = (state == LD_WAIT) && host_valid;

    always_comb begin
        state_next = state;
        load_go    = 1'b0;
        same_next  = (!first_run && (cpu_pc == pc_prev)) ? same_cnt + 1'b1 : '0;
        case (state)
            IDLE: begin
                if (cmd_load) begin
                    state_next = LD_RST;
                    load_go    = 1'b1;
                end else if (cmd_run) begin
                    state_next = RUN;
                end else if (cmd_step) begin
                    state_next = STEP;
                end
            end
            LD_RST:   state_next = LD_WAIT;
            LD_WAIT: begin
                if (accept) state_next = (word_count == WC_MAX) ? LD_END : LD_WRITE;
            end
            LD_WRITE: state_next = LD_ADV;
            LD_ADV:   state_next = last_q ? LD_END : LD_WAIT;
            LD_END:   state_next = IDLE;
            // an explicit halt wins over a halt detected in the same cycle
            RUN: begin
                if (cmd_halt) begin
                    state_next = IDLE;
                end else if (same_next == SC_HALT) begin
                    state_next = HALTED;
                end
            end
            STEP:     state_next = IDLE;
            HALTED: begin
                if (cmd_load) begin
                    state_next = LD_RST;
                    load_go    = 1'b1;
                end else if (cmd_halt) begin
                    state_next = IDLE;
                end
            end
            default:  state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // strobes are registered from the next state so they line up with the state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            host_ready    <= 1'b0;
            cpu_reset     <= 1'b0;
            cpu_start     <= 1'b0;
            cpu_up        <= 1'b0;
            imem_write_en <= 1'b0;
            busy          <= 1'b0;
            halted        <= 1'b0;
        end else begin
            host_ready    <= (state_next == LD_WAIT);
            cpu_reset     <= (state_next == LD_RST) || (state_next == LD_END);
            cpu_start     <= (state_next == RUN) || (state_next == STEP);
            cpu_up        <= (state_next == LD_ADV);
            imem_write_en <= (state_next == LD_WRITE);
            busy          <= (state_next != IDLE) && (state_next != HALTED);
            halted        <= (state_next == HALTED);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            word_count       <= '0;
            cycle_count      <= '0;
            error            <= 1'b0;
            imem_write_instr <= '0;
            last_q           <= 1'b0;
            pc_prev          <= '0;
            same_cnt         <= '0;
            first_run        <= 1'b1;
        end else begin
            if (load_go) begin
                word_count  <= '0;
                cycle_count <= '0;
                error       <= 1'b0;
            end
            if (accept) begin
                imem_write_instr <= host_data;
                last_q           <= host_last;
                if (word_count == WC_MAX) error <= 1'b1;
            end
            if (state == LD_WRITE) word_count <= word_count + 1'b1;
            if (((state == RUN) || (state == STEP)) && (cycle_count != '1)) begin
                cycle_count <= cycle_count + 1'b1;
            end
            // the first RUN cycle has no valid previous PC to compare against
            if (state == RUN) begin
                pc_prev   <= cpu_pc;
                same_cnt  <= same_next;
                first_run <= 1'b0;
            end else begin
                same_cnt  <= '0;
                first_run <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Randomized self-checking bench for cpu_run_ctrl with a toy core/IMEM model; expected
// outputs are queued per cycle from the command scripts and compared on the falling edge.
module tb_cpu_run_ctrl;
    localparam int MAXW = 4;
    localparam int CW   = 4;
    localparam int HR   = 2;
    localparam int CC_MAX = (1 << CW) - 1;
    localparam logic [31:0] LOOP_W = 32'h0000006F;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset = 1'b0;
    logic cmd_load = 1'b0, cmd_run = 1'b0, cmd_step = 1'b0, cmd_halt = 1'b0;
    logic host_valid = 1'b0, host_last = 1'b0;
    logic [31:0] host_data = '0;
    logic host_ready, cpu_reset, cpu_start, cpu_up, cpu_down, imem_write_en;
    logic busy, halted, error;
    logic [31:0] cpu_pc, imem_write_instr;
    logic [2:0] word_count;
    logic [CW-1:0] cycle_count;

    cpu_run_ctrl #(.MAX_WORDS(MAXW), .CYC_W(CW), .HALT_REPEAT(HR)) dut (
        .clk(clk), .reset(reset),
        .cmd_load(cmd_load), .cmd_run(cmd_run), .cmd_step(cmd_step), .cmd_halt(cmd_halt),
        .host_valid(host_valid), .host_data(host_data), .host_last(host_last),
        .host_ready(host_ready), .cpu_pc(cpu_pc), .cpu_reset(cpu_reset),
        .cpu_start(cpu_start), .cpu_up(cpu_up), .cpu_down(cpu_down),
        .imem_write_instr(imem_write_instr), .imem_write_en(imem_write_en),
        .busy(busy), .halted(halted), .error(error),
        .word_count(word_count), .cycle_count(cycle_count)
    );

    // toy core: jal x0,0 holds the PC, anything else falls through
    logic [31:0] imem [0:63];
    logic [31:0] core_pc = '0;
    assign cpu_pc = core_pc;
    always @(posedge clk) begin
        if (cpu_reset) core_pc <= '0;
        else if (imem_write_en) imem[core_pc[7:2]] <= imem_write_instr;
        else if (cpu_up) core_pc <= core_pc + 32'd4;
        else if (cpu_start) core_pc <= (imem[core_pc[7:2]] == LOOP_W) ? core_pc : core_pc + 32'd4;
    end

    typedef struct {
        logic rdy, rst, st, up, we, cwd, bsy, hlt, err;
        logic [31:0] wd;
        int wc, cc;
    } exp_t;
    exp_t exp_q[$];
    exp_t cur;

    int n_cmp = 0, n_bad = 0;
    int m_wc = 0, m_cc = 0, m_pc = 0, m_loop = 0;
    logic m_err = 1'b0, m_halted = 1'b0;
    bit prog_ok = 0, stray_en = 0;
    logic [31:0] prog [0:7];

    int we_cnt = 0, up_cnt = 0, rst_cnt = 0, st_cnt = 0, busy_cnt = 0;
    logic [31:0] wr_log[$];
    logic [31:0] pc_log[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            cur = exp_q.pop_front();
            chk("host_ready", 32'(host_ready), 32'(cur.rdy));
            chk("cpu_reset", 32'(cpu_reset), 32'(cur.rst));
            chk("cpu_start", 32'(cpu_start), 32'(cur.st));
            chk("cpu_up", 32'(cpu_up), 32'(cur.up));
            chk("cpu_down", 32'(cpu_down), 32'd0);
            chk("imem_write_en", 32'(imem_write_en), 32'(cur.we));
            if (cur.cwd) chk("imem_write_instr", imem_write_instr, cur.wd);
            chk("busy", 32'(busy), 32'(cur.bsy));
            chk("halted", 32'(halted), 32'(cur.hlt));
            chk("error", 32'(error), 32'(cur.err));
            chk("word_count", 32'(word_count), 32'(cur.wc));
            chk("cycle_count", 32'(cycle_count), 32'(cur.cc));
            chk("strobe_exclusive",
                32'($countones({cpu_start, cpu_up, cpu_reset, imem_write_en}) > 1), 32'd0);
        end
    end

    always @(negedge clk) begin
        if (imem_write_en) begin we_cnt++; wr_log.push_back(imem_write_instr); end
        if (cpu_up) up_cnt++;
        if (cpu_reset) rst_cnt++;
        if (cpu_start) begin st_cnt++; pc_log.push_back(cpu_pc); end
        if (busy) busy_cnt++;
    end

    function automatic int sat(input int v);
        return (v > CC_MAX) ? CC_MAX : v;
    endfunction

    task automatic push(input logic rdy, rst, st, up, we, input logic [31:0] wd, input logic cwd);
        exp_t e;
        e.rdy = rdy; e.rst = rst; e.st = st; e.up = up; e.we = we;
        e.wd = wd; e.cwd = cwd | we;
        e.bsy = rdy | rst | st | up | we;
        e.hlt = m_halted; e.err = m_err; e.wc = m_wc; e.cc = m_cc;
        exp_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        #1;
        cmd_load = 1'b0; cmd_run = 1'b0; cmd_step = 1'b0; cmd_halt = 1'b0;
    endtask

    task automatic strays(input bit with_halt);
        if (stray_en) begin
            cmd_load = ($urandom_range(0, 4) == 0);
            cmd_run  = ($urandom_range(0, 4) == 0);
            cmd_step = ($urandom_range(0, 4) == 0);
            cmd_halt = with_halt && ($urandom_range(0, 4) == 0);
        end
    endtask

    task automatic clear_mon();
        we_cnt = 0; up_cnt = 0; rst_cnt = 0; st_cnt = 0; busy_cnt = 0;
        wr_log.delete(); pc_log.delete();
    endtask

    task automatic idle(input int n);
        repeat (n) begin push(0, 0, 0, 0, 0, 32'h0, 0); tick(); end
    endtask

    task automatic gen_prog(input int n, input bit loop_last);
        for (int i = 0; i < n; i++) begin
            logic [31:0] w;
            w = $urandom;
            if (w == LOOP_W) w = w ^ 32'h100;
            prog[i] = w;
        end
        if (loop_last) prog[n-1] = LOOP_W;
    endtask

    task automatic do_load(input int n, input bit with_last, input int max_gap, input bit also_run);
        cmd_load = 1'b1; cmd_run = also_run;
        host_valid = (max_gap == 0); host_data = prog[0];
        host_last = with_last && (n == 1);
        m_err = 1'b0; m_wc = 0; m_cc = 0; m_halted = 1'b0;
        push(0, 1, 0, 0, 0, 32'h0, 0); tick();
        strays(1); push(1, 0, 0, 0, 0, 32'h0, 0); tick();
        for (int i = 0; i < n; i++) begin
            int g;
            g = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
            repeat (g) begin
                host_valid = 1'b0; strays(1); push(1, 0, 0, 0, 0, 32'h0, 0); tick();
            end
            host_valid = 1'b1; host_data = prog[i]; host_last = with_last && (i == n - 1);
            strays(1);
            if (m_wc == MAXW) begin
                m_err = 1'b1;
                push(0, 1, 0, 0, 0, 32'h0, 0); tick();
                strays(1); host_valid = 1'b0;
                push(0, 0, 0, 0, 0, 32'h0, 0); tick();
                m_pc = 0;
                return;
            end
            push(0, 0, 0, 0, 1, prog[i], 1); tick();
            strays(1); m_wc++;
            push(0, 0, 0, 1, 0, 32'h0, 0); tick();
            strays(1);
            if (with_last && (i == n - 1)) begin
                push(0, 1, 0, 0, 0, 32'h0, 0); tick();
                strays(1); host_valid = 1'b0;
                push(0, 0, 0, 0, 0, 32'h0, 0); tick();
                m_pc = 0; m_loop = 4 * (n - 1);
                return;
            end
            push(1, 0, 0, 0, 0, 32'h0, 0); tick();
        end
    endtask

    // r_halt / r_rst: RUN cycle (1-based) in which cmd_halt / reset is applied; 0 = never
    task automatic do_run(input int r_halt, input int r_rst);
        int total;
        total = (m_loop - m_pc) / 4 + HR + 1;
        cmd_run = 1'b1;
        push(0, 0, 1, 0, 0, 32'h0, 0); tick();
        for (int j = 1; j <= total; j++) begin
            strays(0);
            if (j == r_rst) begin
                cmd_load = 1'b0; cmd_run = 1'b0; cmd_step = 1'b0; cmd_halt = 1'b0;
                m_err = 1'b0; m_wc = 0; m_cc = 0; m_halted = 1'b0; prog_ok = 0;
                push(0, 0, 0, 0, 0, 32'h0, 1);
                @(posedge clk);
                #1 reset = 1'b0;
                @(negedge clk);
                #1;
                push(0, 0, 0, 0, 0, 32'h0, 1); tick();
                reset = 1'b1;
                push(0, 0, 0, 0, 0, 32'h0, 1); tick();
                return;
            end
            m_cc = sat(m_cc + 1);
            if (j == r_halt) begin
                cmd_halt = 1'b1;
                push(0, 0, 0, 0, 0, 32'h0, 0); tick();
                m_pc = (m_pc + 4 * j > m_loop) ? m_loop : m_pc + 4 * j;
                return;
            end
            if (j == total) begin
                m_halted = 1'b1;
                push(0, 0, 0, 0, 0, 32'h0, 0); tick();
                m_pc = m_loop;
                return;
            end
            push(0, 0, 1, 0, 0, 32'h0, 0); tick();
        end
    endtask

    task automatic do_step();
        cmd_step = 1'b1;
        push(0, 0, 1, 0, 0, 32'h0, 0); tick();
        m_cc = sat(m_cc + 1);
        push(0, 0, 0, 0, 0, 32'h0, 0); tick();
        m_pc = (m_pc + 4 > m_loop) ? m_loop : m_pc + 4;
    endtask

    task automatic ignored_in_halted();
        cmd_run = ($urandom_range(0, 1) == 1);
        cmd_step = !cmd_run || ($urandom_range(0, 1) == 1);
        push(0, 0, 0, 0, 0, 32'h0, 0); tick();
    endtask

    task automatic halt_cmd();
        cmd_halt = 1'b1; m_halted = 1'b0;
        push(0, 0, 0, 0, 0, 32'h0, 0); tick();
    endtask

    task automatic load3();
        prog[0] = 32'h00500093; prog[1] = 32'h00108113; prog[2] = LOOP_W;
        do_load(3, 1, 0, 0);
        prog_ok = 1;
    endtask

    initial begin
        repeat (3) begin push(0, 0, 0, 0, 0, 32'h0, 1); tick(); end
        reset = 1'b1;
        idle(2);

        // three-word load, cmd_run in the same cycle as cmd_load
        prog[0] = 32'h00500093; prog[1] = 32'h00108113; prog[2] = LOOP_W;
        clear_mon();
        do_load(3, 1, 0, 1);
        prog_ok = 1;
        chk("load3_writes", 32'(we_cnt), 32'd3);
        chk("load3_ups", 32'(up_cnt), 32'd3);
        chk("load3_resets", 32'(rst_cnt), 32'd2);
        chk("load3_cycles", 32'(busy_cnt), 32'd11);
        chk("load3_word_count", 32'(word_count), 32'd3);
        for (int i = 0; i < 3; i++)
            chk("load3_data", (wr_log.size() > i) ? wr_log[i] : 32'hDEAD_BEEF, prog[i]);

        // run to halt
        clear_mon();
        do_run(0, 0);
        chk("halt_cycle_count", 32'(cycle_count), 32'd5);
        chk("halt_flag", 32'(halted), 32'd1);
        chk("halt_pc", cpu_pc, 32'd8);
        chk("run_issued", 32'(pc_log.size()), 32'd5);
        for (int i = 0; i < 5; i++)
            chk("run_pc_trace", (pc_log.size() > i) ? pc_log[i] : 32'hDEAD_BEEF,
                (i < 2) ? 32'(4 * i) : 32'd8);

        ignored_in_halted();
        ignored_in_halted();
        halt_cmd();
        repeat (4) begin do_run(0, 0); halt_cmd(); end
        chk("cycle_count_saturated", 32'(cycle_count), 32'd15);

        // single step twice after a reload
        load3();
        clear_mon();
        do_step();
        do_step();
        chk("step_starts", 32'(st_cnt), 32'd2);
        chk("step_pc", cpu_pc, 32'd8);
        chk("step_cycle_count", 32'(cycle_count), 32'd2);

        // overflow: five words, no last flag
        gen_prog(5, 0);
        clear_mon();
        do_load(5, 0, 0, 0);
        prog_ok = 0;
        chk("ovf_error", 32'(error), 32'd1);
        chk("ovf_word_count", 32'(word_count), 32'd4);
        chk("ovf_writes", 32'(we_cnt), 32'd4);
        for (int i = 0; i < 4; i++)
            chk("ovf_data", (wr_log.size() > i) ? wr_log[i] : 32'hDEAD_BEEF, prog[i]);
        idle(1);

        // cmd_halt on the cycle the halt is detected
        load3();
        do_run(5, 0);
        chk("halt_race_halted", 32'(halted), 32'd0);
        chk("halt_race_busy", 32'(busy), 32'd0);

        // asynchronous reset in the middle of a run
        do_run(0, 2);

        stray_en = 1;
        for (int it = 0; it < 80; it++) begin
            int op;
            op = $urandom_range(0, 9);
            if (!prog_ok) op = 0;
            if (m_halted) begin
                if (op < 3) op = 0;
                else if (op < 6) begin ignored_in_halted(); continue; end
                else begin halt_cmd(); continue; end
            end
            case (op)
                0, 1: begin
                    if ($urandom_range(0, 4) == 0) begin
                        gen_prog(5, 0);
                        do_load(5, $urandom_range(0, 1) == 1, 2, 0);
                        prog_ok = 0;
                    end else begin
                        int n;
                        n = $urandom_range(1, 4);
                        gen_prog(n, 1);
                        do_load(n, 1, 2, $urandom_range(0, 1) == 1);
                        prog_ok = 1;
                    end
                end
                2, 3, 4, 9: do_run($urandom_range(0, 8),
                                   ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 4)) : 0);
                5, 6: do_step();
                7: idle($urandom_range(1, 3));
                default: halt_cmd();
            endcase
        end
        stray_en = 0;
        idle(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
